// File: rtl/clk_period_meter.sv
// Measures rise-to-rise period and high time of sig_i in clk_i cycles.
// One start_i request yields one result or a timeout on counter overflow.
module clk_period_meter #(
    parameter int CNT_WIDTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    input  logic                 sig_i,
    input  logic                 start_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 timeout_o,
    output logic [CNT_WIDTH-1:0] period_o,
    output logic [CNT_WIDTH-1:0] high_o
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEAS,
        DONE
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d_q;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   hcnt_q, hcnt_d;
    logic [CNT_WIDTH-1:0]   period_q, period_d;
    logic [CNT_WIDTH-1:0]   high_q, high_d;
    logic                   timeout_q, timeout_d;
    logic                   s;
    logic                   rise;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q[0] <= sig_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            s_d_q <= s;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d_q;

    // A rise always wins over an overflow on the same cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hcnt_d    = hcnt_q;
        period_d  = period_q;
        high_d    = high_q;
        timeout_d = timeout_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d   = ARM;
                    cnt_d     = '0;
                    hcnt_d    = '0;
                    timeout_d = 1'b0;
                end
            end
            ARM: begin
                if (rise) begin
                    state_d = MEAS;
                    cnt_d   = CNT_ONE;
                    hcnt_d  = CNT_ONE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = DONE;
                    period_d  = CNT_MAX;
                    high_d    = hcnt_q;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            MEAS: begin
                if (rise) begin
                    state_d  = DONE;
                    period_d = cnt_q;
                    high_d   = hcnt_q;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = DONE;
                    period_d  = CNT_MAX;
                    high_d    = hcnt_q;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (s && hcnt_q != CNT_MAX) begin
                        hcnt_d = hcnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            period_q  <= '0;
            high_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hcnt_q    <= hcnt_d;
            period_q  <= period_d;
            high_q    <= high_d;
            timeout_q <= timeout_d;
        end
    end

    assign busy_o    = (state_q == ARM) || (state_q == MEAS);
    assign done_o    = (state_q == DONE);
    assign timeout_o = timeout_q;
    assign period_o  = period_q;
    assign high_o    = high_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter: a 16-bit instance and an 8-bit instance
// for overflow boundaries, expected results queued at each start.
module tb_clk_period_meter;

    logic        clk    = 1'b0;
    logic        arst   = 1'b1;
    logic        sig    = 1'b0;
    logic        start  = 1'b0;
    logic        start8 = 1'b0;
    logic        use8   = 1'b0;
    logic        sig8;
    logic        busy, done, tout;
    logic [15:0] period, high;
    logic        busy8, done8, tout8;
    logic [7:0]  period8, high8;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] p;
        logic [15:0] h;
        logic        t;
    } exp_t;

    exp_t sb[$];

    int gen_p  = 8;
    int gen_h  = 3;
    int gen_ph = 0;
    bit gen_en = 1'b0;

    always #5 clk = ~clk;

    assign sig8 = use8 ? sig : 1'b0;

    clk_period_meter dut (
        .clk_i    (clk),
        .arst_i   (arst),
        .sig_i    (sig),
        .start_i  (start),
        .busy_o   (busy),
        .done_o   (done),
        .timeout_o(tout),
        .period_o (period),
        .high_o   (high)
    );

    clk_period_meter #(.CNT_WIDTH(8), .SYNC_STAGES(2)) dut8 (
        .clk_i    (clk),
        .arst_i   (arst),
        .sig_i    (sig8),
        .start_i  (start8),
        .busy_o   (busy8),
        .done_o   (done8),
        .timeout_o(tout8),
        .period_o (period8),
        .high_o   (high8)
    );

    // Periodic stimulus: high for gen_h of every gen_p clk cycles.
    always @(negedge clk) begin
        if (gen_en) begin
            sig    = (gen_ph < gen_h);
            gen_ph = (gen_ph + 1 >= gen_p) ? 0 : gen_ph + 1;
        end else begin
            sig = 1'b0;
        end
    end

    task automatic set_gen(input int p, input int h);
        @(negedge clk);
        #1;
        gen_p  = p;
        gen_h  = h;
        gen_ph = 0;
        gen_en = 1'b1;
        repeat (p + 8) @(negedge clk);
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic start8_pulse();
        @(negedge clk);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int n);
        n = 0;
        while (done !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_done8(input int bound, output int n);
        n = 0;
        while (done8 !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic measure(input int p, input int h, output bit ok);
        int n;
        set_gen(p, h);
        sb.push_back('{p: 16'(p), h: 16'(h), t: 1'b0});
        start_pulse();
        wait_done(3 * p + 20, n);
        ok = (done === 1'b1);
    endtask

    // Start the 8-bit instance just before a rise so ARM never overflows.
    task automatic measure8(input int p, input int h, input logic t,
                            output bit ok);
        int n;
        use8 = 1'b1;
        set_gen(p, h);
        for (int i = 0; i < 2 * p; i++) begin
            @(negedge clk);
            #1;
            if (gen_ph == p - 4) break;
        end
        sb.push_back('{p: 16'h00FF, h: 16'(h), t: t});
        start8_pulse();
        wait_done8(3 * p + 20, n);
        ok = (done8 === 1'b1);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || tout !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got %b%b%b want 000", busy, done, tout);
        end
        checks++;
        if (period !== 16'h0 || high !== 16'h0) begin
            failures++;
            $display("FAIL reset_counts got %0h/%0h want 0/0", period, high);
        end
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || period8 !== 8'h0) begin
            failures++;
            $display("FAIL reset_dut8 got %b%b %0h want 00 0",
                     busy8, done8, period8);
        end
        repeat (3) @(negedge clk);
        arst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        exp_t e;
        int   n;
        set_gen(8, 3);
        sb.push_back('{p: 16'd8, h: 16'd3, t: 1'b0});
        start_pulse();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL basic_armed got busy=%b done=%b want 1 0", busy, done);
        end
        wait_done(40, n);
        e = sb.pop_front();
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL basic_done got %b want 1", done);
        end
        checks++;
        if (period !== e.p || high !== e.h || tout !== e.t) begin
            failures++;
            $display("FAIL basic_result got %0d/%0d/%b want %0d/%0d/%b",
                     period, high, tout, e.p, e.h, e.t);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy got %b want 0", busy);
        end
    endtask

    task automatic test_min_period();
        exp_t e;
        bit   ok;
        measure(2, 1, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || period !== e.p || high !== e.h || tout !== e.t) begin
            failures++;
            $display("FAIL min_period got %b %0d/%0d/%b want 1 %0d/%0d/%b",
                     done, period, high, tout, e.p, e.h, e.t);
        end
    endtask

    task automatic test_divider();
        int   pt[2] = '{4, 15};
        int   ht[2] = '{2, 7};
        exp_t e;
        bit   ok;
        for (int i = 0; i < 2; i++) begin
            measure(pt[i], ht[i], ok);
            e = sb.pop_front();
            checks++;
            if (!ok || period !== e.p || high !== e.h || tout !== e.t) begin
                failures++;
                $display("FAIL divider_%0d got %b %0d/%0d/%b want 1 %0d/%0d/%b",
                         pt[i], done, period, high, tout, e.p, e.h, e.t);
            end
        end
    endtask

    task automatic test_ignore_start();
        exp_t e;
        set_gen(8, 3);
        sb.push_back('{p: 16'd8, h: 16'd3, t: 1'b0});
        start_pulse();
        for (int i = 2; i <= 17; i++) begin
            @(negedge clk);
            if (done === 1'b1) break;
            start = busy && (i % 3 == 0);
        end
        start = 1'b0;
        e = sb.pop_front();
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL ignore_start_late got done=%b want 1", done);
        end
        checks++;
        if (period !== e.p || high !== e.h || tout !== e.t) begin
            failures++;
            $display("FAIL ignore_start got %0d/%0d/%b want %0d/%0d/%b",
                     period, high, tout, e.p, e.h, e.t);
        end
    endtask

    task automatic test_restart_done();
        exp_t e;
        int   n;
        set_gen(5, 2);
        sb.push_back('{p: 16'd5, h: 16'd2, t: 1'b0});
        start_pulse();
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL restart_drop got done=%b busy=%b want 0 1", done, busy);
        end
        wait_done(40, n);
        e = sb.pop_front();
        checks++;
        if (done !== 1'b1 || period !== e.p || high !== e.h) begin
            failures++;
            $display("FAIL restart_result got %b %0d/%0d want 1 %0d/%0d",
                     done, period, high, e.p, e.h);
        end
    endtask

    task automatic test_abort();
        bit seen = 1'b0;
        set_gen(40, 10);
        start_pulse();
        repeat (15) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_busy got %b want 1", busy);
        end
        #2;
        arst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || tout !== 1'b0) begin
            failures++;
            $display("FAIL abort_flags got %b%b%b want 000", busy, done, tout);
        end
        checks++;
        if (period !== 16'h0 || high !== 16'h0) begin
            failures++;
            $display("FAIL abort_counts got %0h/%0h want 0/0", period, high);
        end
        @(negedge clk);
        arst = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL abort_release got activity=%b want 0", seen);
        end
    endtask

    task automatic test_timeout8();
        exp_t e;
        int   n;
        use8 = 1'b0;
        sb.push_back('{p: 16'h00FF, h: 16'h0, t: 1'b1});
        start8_pulse();
        wait_done8(400, n);
        e = sb.pop_front();
        checks++;
        if (done8 !== 1'b1 || n < 255 || n > 256) begin
            failures++;
            $display("FAIL timeout8_cycles got done=%b after %0d want 1 after 255..256",
                     done8, n);
        end
        checks++;
        if ({8'h0, period8} !== e.p || {8'h0, high8} !== e.h || tout8 !== e.t) begin
            failures++;
            $display("FAIL timeout8_result got %0h/%0h/%b want %0h/%0h/%b",
                     period8, high8, tout8, e.p, e.h, e.t);
        end
        checks++;
        if (busy8 !== 1'b0) begin
            failures++;
            $display("FAIL timeout8_busy got %b want 0", busy8);
        end
    endtask

    task automatic test_boundary8();
        exp_t e;
        bit   ok;
        measure8(255, 100, 1'b0, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || {8'h0, period8} !== e.p || {8'h0, high8} !== e.h ||
            tout8 !== e.t) begin
            failures++;
            $display("FAIL bound255 got %b %0h/%0d/%b want 1 %0h/%0d/%b",
                     done8, period8, high8, tout8, e.p, e.h, e.t);
        end
        measure8(256, 100, 1'b1, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || {8'h0, period8} !== e.p || {8'h0, high8} !== e.h ||
            tout8 !== e.t) begin
            failures++;
            $display("FAIL bound256 got %b %0h/%0d/%b want 1 %0h/%0d/%b",
                     done8, period8, high8, tout8, e.p, e.h, e.t);
        end
        use8 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_min_period();
        test_divider();
        test_ignore_start();
        test_restart_done();
        test_abort();
        test_timeout8();
        test_boundary8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
